// File: rtl/m452_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m452_pkg
// Description : Shared constants and elaboration-time helpers for the
//               multi-channel variable baud clock.
//               RATE_TABLE  - eight baud rates packed 16 bits each, entry k
//                             at [16*k +: 16]
//               limit_for() - rounded terminal count for one rate
//               cnt_width() - prescaler width, sized from the slowest rate
// Revision    : 1.0 - initial release
// ============================================================================
package m452_pkg;

    localparam int unsigned c_rate_w = 16;

    // Index 0 is the slowest rate; it sizes the prescaler counter.
    localparam logic [8*c_rate_w-1:0] RATE_TABLE = {
        16'd9600, 16'd4800, 16'd2400, 16'd1200,
        16'd600,  16'd300,  16'd150,  16'd110
    };

    // round(clk_hz / (oversample * rate)) - 1, using integer round-half-up.
    function automatic int unsigned limit_for(input int unsigned clk_hz,
                                              input int unsigned oversample,
                                              input int unsigned rate);
        int unsigned d;
        d = oversample * rate;
        return ((clk_hz + (d / 2)) / d) - 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned clk_hz,
                                              input int unsigned oversample);
        return $clog2(limit_for(clk_hz, oversample,
                                32'(RATE_TABLE[c_rate_w-1:0])) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m452_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : m452_multi_if
// Description : Bundled per-channel control and status buses.
//               en    [NCHAN]          run enable
//               sel   [3*NCHAN]        rate select, channel i at [3i +: 3]
//               trig  [NCHAN]          pulse-stretcher input
//               tick  [NCHAN]          oversampled baud strobe
//               div   [DIV_BITS*NCHAN] divided counts
//               div_n [DIV_BITS*NCHAN] complement of div
//               pulse [NCHAN]          stretched pulse
//               master drives the controls, slave (the clock block) the status.
// Revision    : 1.0 - initial release
// ============================================================================
interface m452_multi_if #(
    parameter int unsigned NCHAN    = 2,
    parameter int unsigned DIV_BITS = 3
);
    logic [NCHAN-1:0]          en;
    logic [3*NCHAN-1:0]        sel;
    logic [NCHAN-1:0]          trig;
    logic [NCHAN-1:0]          tick;
    logic [DIV_BITS*NCHAN-1:0] div;
    logic [DIV_BITS*NCHAN-1:0] div_n;
    logic [NCHAN-1:0]          pulse;

    modport master (output en, sel, trig, input tick, div, div_n, pulse);
    modport slave  (input en, sel, trig, output tick, div, div_n, pulse);
endinterface
`default_nettype wire

// File: rtl/m452_chan.sv
`default_nettype none
// ============================================================================
// Module      : m452_chan
// Description : One baud clock channel: table-driven prescaler with a
//               period-latched limit, divided-clock counter and a
//               retriggerable falling-edge pulse stretcher.
//               clk, reset - system clock, synchronous active-high reset
//               en, sel    - run enable, rate select
//               trig       - stretcher input
//               tick       - one-cycle strobe every lim+1 cycles
//               div, div_n - divided count and its complement
//               pulse      - stretched pulse
// Revision    : 1.0 - initial release
// ============================================================================
module m452_chan
    import m452_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_BITS     = 3,
    parameter int unsigned PULSE_CYCLES = 10
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                en,
    input  wire logic [2:0]          sel,
    input  wire logic                trig,
    output logic                     tick,
    output logic [DIV_BITS-1:0]      div,
    output logic [DIV_BITS-1:0]      div_n,
    output logic                     pulse
);

    localparam int unsigned c_cnt_w = cnt_width(CLK_HZ, OVERSAMPLE);

    logic [c_cnt_w-1:0]  w_lim_tab [8];
    logic [c_cnt_w-1:0]  w_sel_lim;

    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  r_lim;
    logic [DIV_BITS-1:0] r_div;
    logic                r_tick;
    logic                r_trig_prev;
    logic [7:0]          r_pcnt;
    logic                w_fall;

    // Terminal counts are elaboration constants; only the 8:1 mux is logic.
    for (genvar k = 0; k < 8; k++) begin : g_lim
        localparam int unsigned c_lim =
            limit_for(CLK_HZ, OVERSAMPLE, 32'(RATE_TABLE[c_rate_w*k +: c_rate_w]));
        assign w_lim_tab[k] = c_lim[c_cnt_w-1:0];
    end

    assign w_sel_lim = w_lim_tab[sel];
    assign w_fall    = r_trig_prev & ~trig;

    // r_lim only follows sel at a wrap or while idle, so a rate change
    // never alters the period already in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_lim   <= w_sel_lim;
            r_div   <= '0;
            r_tick  <= 1'b0;
        end else if (!en) begin
            r_count <= '0;
            r_lim   <= w_sel_lim;
            r_tick  <= 1'b0;
        end else if (r_count == r_lim) begin
            r_count <= '0;
            r_lim   <= w_sel_lim;
            r_div   <= r_div + DIV_BITS'(1);
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
            r_tick  <= 1'b0;
        end
    end

    // Stretcher runs regardless of en. trig_prev resets low so a trig held
    // low across reset is not mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trig_prev <= 1'b0;
            r_pcnt      <= '0;
        end else begin
            r_trig_prev <= trig;
            if (w_fall) begin
                r_pcnt <= 8'(PULSE_CYCLES);
            end else if (r_pcnt != 8'd0) begin
                r_pcnt <= r_pcnt - 8'd1;
            end
        end
    end

    assign tick  = r_tick;
    assign div   = r_div;
    assign div_n = ~r_div;
    assign pulse = (r_pcnt != 8'd0);

endmodule
`default_nettype wire

// File: rtl/m452_multi.sv
`default_nettype none
// ============================================================================
// Module      : m452_multi
// Description : NCHAN independent baud clock channels behind one bus
//               interface. Channels share only clk and reset.
//               clk   - system clock, all logic on posedge
//               reset - synchronous active-high reset
//               bus   - m452_multi_if slave: en/sel/trig in,
//                       tick/div/div_n/pulse out (flattened per channel)
//               The interface must be instantiated with the same NCHAN and
//               DIV_BITS as this module.
// Revision    : 1.0 - initial release
// ============================================================================
module m452_multi
    import m452_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned NCHAN        = 2,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_BITS     = 3,
    parameter int unsigned PULSE_CYCLES = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    m452_multi_if.slave   bus
);

    logic [NCHAN-1:0]          w_tick;
    logic [NCHAN-1:0]          w_pulse;
    logic [DIV_BITS*NCHAN-1:0] w_div;
    logic [DIV_BITS*NCHAN-1:0] w_div_n;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        m452_chan #(
            .CLK_HZ       (CLK_HZ),
            .OVERSAMPLE   (OVERSAMPLE),
            .DIV_BITS     (DIV_BITS),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .en    (bus.en[i]),
            .sel   (bus.sel[3*i +: 3]),
            .trig  (bus.trig[i]),
            .tick  (w_tick[i]),
            .div   (w_div[DIV_BITS*i +: DIV_BITS]),
            .div_n (w_div_n[DIV_BITS*i +: DIV_BITS]),
            .pulse (w_pulse[i])
        );
    end

    assign bus.tick  = w_tick;
    assign bus.div   = w_div;
    assign bus.div_n = w_div_n;
    assign bus.pulse = w_pulse;

endmodule
`default_nettype wire

// File: tb/tb_m452_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_m452_multi
// Description : Self-checking bench for m452_multi at default parameters.
//               Channel 0 runs at 110 baud from just after reset while all
//               directed sequences exercise channel 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m452_multi;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    m452_multi_if #(.NCHAN(2), .DIV_BITS(3)) bus ();

    m452_multi #(
        .CLK_HZ       (100000000),
        .NCHAN        (2),
        .OVERSAMPLE   (16),
        .DIV_BITS     (3),
        .PULSE_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // div_n must mirror div on every cycle.
    bit mon_on = 1'b0;
    int dn_bad = 0;
    always @(negedge clk) begin
        if (mon_on && (bus.div_n !== ~bus.div)) dn_bad = dn_bad + 1;
    end

    // Channel 0 first-tick capture.
    int ch0_start = -1;
    int ch0_first = -1;
    always @(negedge clk) begin
        if (ch0_start >= 0 && ch0_first < 0 && bus.tick[0] === 1'b1) ch0_first = cyc;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the cycle of the next tick on channel ch, or -1 if none within bound.
    task automatic wait_tick(input int ch, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(posedge clk);
            #1;
            if (bus.tick[ch] === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic int div_of(input int ch);
        logic [5:0] d;
        d = bus.div;
        return int'(d[3*ch +: 3]);
    endfunction

    typedef struct {
        int         ch;
        logic [2:0] sel;
        int         period;
    } vec_t;

    vec_t vecs [4];
    int   exp_div [2];

    initial begin
        int t0, t1, t2, n, cnt;
        bit exp_p;

        vecs[0] = '{ch: 1, sel: 3'd7, period: 651};
        vecs[1] = '{ch: 1, sel: 3'd6, period: 1302};
        vecs[2] = '{ch: 1, sel: 3'd5, period: 2604};
        vecs[3] = '{ch: 1, sel: 3'd4, period: 5208};
        exp_div[0] = 0;
        exp_div[1] = 0;

        bus.en   = 2'b00;
        bus.sel  = 6'd0;
        bus.trig = 2'b00;
        reset    = 1'b1;
        step(3);
        reset = 1'b0;

        chk("reset_tick",  int'(bus.tick),  0);
        chk("reset_div",   int'(bus.div),   0);
        chk("reset_div_n", int'(bus.div_n), 63);
        chk("reset_pulse", int'(bus.pulse), 0);
        mon_on = 1'b1;

        // Channel 0: slowest rate, runs underneath everything below.
        bus.sel[2:0] = 3'd0;
        bus.en[0]    = 1'b1;
        ch0_start    = cyc;

        // Table: first tick after enable and the following period.
        for (int v = 0; v < 4; v++) begin
            bus.en[vecs[v].ch] = 1'b0;
            bus.sel[3*vecs[v].ch +: 3] = vecs[v].sel;
            step(2);
            bus.en[vecs[v].ch] = 1'b1;
            t0 = cyc;
            wait_tick(vecs[v].ch, vecs[v].period + 10, t1);
            chk($sformatf("vec%0d_first_tick", v), t1 - t0, vecs[v].period);
            exp_div[vecs[v].ch] = (exp_div[vecs[v].ch] + 1) % 8;
            chk($sformatf("vec%0d_div_a", v), div_of(vecs[v].ch), exp_div[vecs[v].ch]);
            wait_tick(vecs[v].ch, vecs[v].period + 10, t2);
            chk($sformatf("vec%0d_period", v), t2 - t1, vecs[v].period);
            exp_div[vecs[v].ch] = (exp_div[vecs[v].ch] + 1) % 8;
            chk($sformatf("vec%0d_div_b", v), div_of(vecs[v].ch), exp_div[vecs[v].ch]);
        end

        // sel 7 -> 6 mid-period: current period unchanged, next one longer.
        bus.en[1] = 1'b0;
        bus.sel[5:3] = 3'd7;
        step(2);
        bus.en[1] = 1'b1;
        wait_tick(1, 700, t1);
        exp_div[1] = (exp_div[1] + 1) % 8;
        step(300);
        bus.sel[5:3] = 3'd6;
        wait_tick(1, 700, t2);
        chk("selchg_old_period", t2 - t1, 651);
        exp_div[1] = (exp_div[1] + 1) % 8;
        wait_tick(1, 1400, t1);
        chk("selchg_new_period", t1 - t2, 1302);
        exp_div[1] = (exp_div[1] + 1) % 8;
        chk("selchg_div", div_of(1), exp_div[1]);

        // en dropped at count 400 for 50 cycles.
        bus.en[1] = 1'b0;
        bus.sel[5:3] = 3'd7;
        step(2);
        bus.en[1] = 1'b1;
        wait_tick(1, 700, t1);
        exp_div[1] = (exp_div[1] + 1) % 8;
        step(400);
        bus.en[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (bus.tick[1] === 1'b1) cnt = cnt + 1;
        end
        chk("endrop_no_tick", cnt, 0);
        chk("endrop_div_held", div_of(1), exp_div[1]);
        bus.en[1] = 1'b1;
        t0 = cyc;
        wait_tick(1, 700, t1);
        chk("endrop_restart", t1 - t0, 651);
        exp_div[1] = (exp_div[1] + 1) % 8;
        chk("endrop_div_after", div_of(1), exp_div[1]);

        // en dropped exactly when count == lim: no tick, no increment.
        step(650);
        bus.en[1] = 1'b0;
        step(1);
        chk("enlim_no_tick", int'(bus.tick[1]), 0);
        chk("enlim_div_held", div_of(1), exp_div[1]);
        bus.en[1] = 1'b1;
        t0 = cyc;
        wait_tick(1, 700, t1);
        chk("enlim_restart", t1 - t0, 651);
        exp_div[1] = (exp_div[1] + 1) % 8;

        // Pulse stretcher with retrigger on channel 1; channel 0 trig stays low.
        bus.trig[1] = 1'b1;
        cnt = 0;
        for (int r = 1; r <= 30; r++) begin
            step(1);
            exp_p = (r >= 11) && (r <= 25);
            chk($sformatf("pulse_r%0d", r), int'(bus.pulse[1]), int'(exp_p));
            if (bus.pulse[0] === 1'b1) cnt = cnt + 1;
            if (r == 10) bus.trig[1] = 1'b0;
            if (r == 12) bus.trig[1] = 1'b1;
            if (r == 15) bus.trig[1] = 1'b0;
        end
        chk("pulse_ch0_quiet", cnt, 0);

        // Channel 0 at 110 baud, unaffected by channel 1 activity.
        n = 0;
        while (ch0_first < 0 && n < 60000) begin
            step(1);
            n = n + 1;
        end
        chk("ch0_sel0_first_tick", ch0_first - ch0_start, 56818);
        exp_div[0] = 1;
        chk("ch0_div", div_of(0), exp_div[0]);

        // Reset mid-pulse with div == 5; trig held low through reset.
        for (int i = 0; i < 8 && exp_div[1] != 5; i++) begin
            wait_tick(1, 700, t1);
            exp_div[1] = (exp_div[1] + 1) % 8;
        end
        chk("rst_pre_div5", div_of(1), 5);
        bus.trig[1] = 1'b1;
        step(2);
        bus.trig[1] = 1'b0;
        step(3);
        chk("rst_pre_pulse", int'(bus.pulse[1]), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        t0 = cyc;
        chk("rst_div",   int'(bus.div),   0);
        chk("rst_div_n", int'(bus.div_n), 63);
        chk("rst_pulse", int'(bus.pulse), 0);
        chk("rst_tick",  int'(bus.tick),  0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (bus.pulse[1] === 1'b1) cnt = cnt + 1;
        end
        chk("rst_no_false_pulse", cnt, 0);
        wait_tick(1, 700, t1);
        chk("rst_first_tick", t1 - t0, 651);
        chk("rst_div_after", div_of(1), 1);

        chk("div_n_complement", dn_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
